// File: rtl/reg_file_pkg.sv
// Shared sizing constants for the write-port register file.
package reg_file_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/reg_file_wp_decoder.sv
// Binary-to-one-hot decoder with enable, used for the register write strobe.
module decoder_n_to_onehot #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   en_i,
  output logic [2**ADDR_W-1:0]   onehot_o
);
  // NOTE: the default assignment first keeps this combinational block latch-free,
  // and the enable gate keeps an unknown address from reaching the strobes.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end
endmodule

// File: rtl/reg_file_wp.sv
// Two-read, one-write register file with hardwired-zero register 0.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_wp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_W-1:0]    raddr1,
  input  logic [ADDR_W-1:0]    raddr2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2,
  output logic [2**ADDR_W-1:0] wr_onehot
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_en;

  assign wr_en = we && !rst && (waddr != ZERO_ADDR);

  decoder_n_to_onehot #(.ADDR_W(ADDR_W)) u_dec (
    .addr_i   (waddr),
    .en_i     (wr_en),
    .onehot_o (wr_onehot)
  );

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_onehot[i]) regs_d[i] = wdata;
    end
  end

  // NOTE: this array is reset because rst must clear every register at once;
  // plain RAM storage would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    if (rst || ra == ZERO_ADDR) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && ra == waddr) return wdata;
`endif
    return regs_q[ra];
  endfunction

  assign rdata1 = read_port(raddr1);
  assign rdata2 = read_port(raddr2);
endmodule

// File: tb/tb_reg_file_wp.sv
// Scoreboard bench for reg_file_wp: stimulus queues expectations, a negedge monitor checks them.
module tb_reg_file_wp;
  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr, raddr1, raddr2;
  logic [DW-1:0] wdata, rdata1, rdata2;
  logic [31:0]   wr_onehot;

  reg_file_wp #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wr_onehot(wr_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = sb_q.pop_front();
        case (e.sel)
          0:       act = {16'h0, rdata1};
          1:       act = {16'h0, rdata2};
          default: act = wr_onehot;
        endcase
        check(e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic wait_checked();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (sb_q.size() == 0) return;
    end
    errors++;
    $display("FAIL monitor_timeout pending=%0d required=0", sb_q.size());
    sb_q.delete();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    tick(); tick();

    // Writes and reads are suppressed while reset is held.
    we = 1'b1; waddr = 5'd7; wdata = 16'hFFFF; raddr1 = 5'd7; raddr2 = 5'd5;
    expect_val("rst_onehot", 2, 32'h0);
    expect_val("rst_rd1_bypass", 0, 32'h0);
    expect_val("rst_rd2", 1, 32'h0);
    wait_checked();
    tick();
    we = 1'b0; rst = 1'b0;
    expect_val("rst_write_lost", 0, 32'h0);
    wait_checked();

    // Write then read.
    tick();
    we = 1'b1; waddr = 5'd7; wdata = 16'hBEEF; raddr2 = 5'd7;
    #1;
    check("wr7_onehot_direct", wr_onehot, 32'h0000_0080);
    expect_val("wr7_onehot", 2, 32'h0000_0080);
    wait_checked();
    tick();
    we = 1'b0;
    expect_val("rd7", 1, 32'hBEEF);
    wait_checked();

    // Zero register.
    tick();
    we = 1'b1; waddr = 5'd0; wdata = 16'hFFFF; raddr1 = 5'd0;
    #1;
    check("zero_onehot_direct", wr_onehot, 32'h0);
    expect_val("zero_onehot", 2, 32'h0);
    expect_val("zero_rd_during", 0, 32'h0);
    wait_checked();
    tick();
    we = 1'b0;
    expect_val("zero_rd_after", 0, 32'h0);
    wait_checked();

    // Same-cycle read of the write target.
    tick();
    write_reg(5'd3, 16'h1111);
    we = 1'b1; waddr = 5'd3; wdata = 16'h2222; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("same_cycle_rd1_direct", {16'h0, rdata1}, 32'h2222);
    expect_val("same_cycle_rd1", 0, 32'h2222);
    expect_val("same_cycle_rd2", 1, 32'h2222);
`else
    check("same_cycle_rd1_direct", {16'h0, rdata1}, 32'h1111);
    expect_val("same_cycle_rd1", 0, 32'h1111);
    expect_val("same_cycle_rd2", 1, 32'h1111);
`endif
    wait_checked();
    tick();
    we = 1'b0;
    expect_val("post_edge_rd1", 0, 32'h2222);
    expect_val("post_edge_rd2", 1, 32'h2222);
    wait_checked();

    // we=0 leaves contents alone, even with an unknown address.
    tick();
    write_reg(5'd9, 16'h5A5A);
    we = 1'b0; waddr = 5'd9; wdata = 16'hAAAA; raddr1 = 5'd9;
    tick(); tick(); tick();
    expect_val("we0_reg9", 0, 32'h5A5A);
    wait_checked();
    waddr = 'x;
    expect_val("we0_x_onehot", 2, 32'h0);
    wait_checked();
    tick();
    expect_val("we0_x_reg9", 0, 32'h5A5A);
    wait_checked();
    waddr = '0;

    // Sweep: reg[i] = i*0x0101, read back on both ports in opposite orders.
    tick();
    for (int i = 1; i < 32; i++) write_reg(AW'(i), DW'(i * 16'h0101));
    for (int i = 0; i < 32; i++) begin
      raddr1 = AW'(i); raddr2 = AW'(31 - i);
      expect_val($sformatf("sweep_rd1_%0d", i), 0, 32'(i * 16'h0101));
      expect_val($sformatf("sweep_rd2_%0d", 31 - i), 1, 32'((31 - i) * 16'h0101));
      wait_checked();
    end

    // Reset mid-run clears everything without a clock edge.
    write_reg(5'd5, 16'h1234);
    raddr1 = 5'd5;
    expect_val("reg5_before_rst", 0, 32'h1234);
    wait_checked();
    tick(); #1;
    rst = 1'b1;
    #1;
    check("reg5_async_clear_direct", {16'h0, rdata1}, 32'h0);
    expect_val("reg5_async_clear", 0, 32'h0);
    wait_checked();
    for (int i = 0; i < 32; i++) begin
      raddr1 = AW'(i); raddr2 = AW'(i);
      expect_val($sformatf("rst_all_rd1_%0d", i), 0, 32'h0);
      expect_val($sformatf("rst_all_rd2_%0d", i), 1, 32'h0);
    end
    wait_checked();

    // First write after reset release lands normally.
    tick();
    rst = 1'b0;
    write_reg(5'd5, 16'h4321);
    raddr1 = 5'd5; raddr2 = 5'd7;
    #1;
    check("post_rst_write_direct", {16'h0, rdata1}, 32'h4321);
    expect_val("post_rst_write", 0, 32'h4321);
    expect_val("post_rst_reg7", 1, 32'h0);
    wait_checked();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
